// File: rtl/scoreboard_reg_file.sv
// Register file with two combinational read ports, one write port, register 0 tied to zero,
// optional write-to-read bypass and a per-register pending-write scoreboard for ID-stage stalls.
module scoreboard_reg_file #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic              regwrite,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wr,
    output logic              iss_ready,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int   NREGS = 2 ** ADDR_W;
    localparam logic BYP   = (BYPASS != 0);

    logic [WIDTH-1:0] regs [1:NREGS-1];
    logic [NREGS-1:1] pending;

    // Index-0 views so reads can use any address; slot 0 is a constant, not storage.
    logic [WIDTH-1:0] reg_view [NREGS];
    logic [NREGS-1:0] pend_view;

    always_comb begin
        reg_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            reg_view[i] = regs[i];
        end
        pend_view = {pending, 1'b0};
    end

    // Issue handshake: a request (iss_valid) is taken on an edge where iss_ready is high;
    // while iss_ready is low the requester holds iss_valid and iss_wr stable (WAW stall).
    // A writeback to the same register in the same cycle frees the slot for the new issue.
    logic wr_hits_iss;
    logic iss_fire;

    always_comb begin
        wr_hits_iss = regwrite && (wr == iss_wr);
        iss_ready   = (iss_wr == '0) || !pend_view[iss_wr] || wr_hits_iss;
        iss_fire    = iss_valid && iss_ready && (iss_wr != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i]    <= '0;
                pending[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (regwrite && (wr == ADDR_W'(i))) begin
                    regs[i]    <= wd;
                    pending[i] <= 1'b0;
                end
                // Placed after the clear so a same-cycle issue leaves the register pending.
                if (iss_fire && (iss_wr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    logic hit1;
    logic hit2;

    always_comb begin
        hit1  = BYP && regwrite && (wr == rr1);
        hit2  = BYP && regwrite && (wr == rr2);

        rd1   = (rr1 == '0) ? '0 : (hit1 ? wd : reg_view[rr1]);
        rd2   = (rr2 == '0) ? '0 : (hit2 ? wd : reg_view[rr2]);

        busy1 = (rr1 != '0) && pend_view[rr1] && !hit1;
        busy2 = (rr2 != '0) && pend_view[rr2] && !hit2;
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 1; i < NREGS; i++) begin
            pend_cnt = pend_cnt + (ADDR_W + 1)'(pending[i]);
        end
    end

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench for scoreboard_reg_file: one bypassing instance and one non-bypassing
// instance share all inputs so forwarding behaviour can be compared cycle by cycle.
module tb_scoreboard_reg_file;

    logic        clk;
    logic        reset;
    logic [1:0]  rr1, rr2, wr, iss_wr;
    logic [15:0] wd;
    logic        regwrite, iss_valid;

    logic [15:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        busy1, busy2, busy1_nb, busy2_nb;
    logic        iss_ready, iss_ready_nb;
    logic [2:0]  pend_cnt, pend_cnt_nb;

    int total  = 0;
    int passed = 0;

    scoreboard_reg_file #(.WIDTH(16), .ADDR_W(2), .BYPASS(1)) dut (
        .clock(clk), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .wr(wr), .wd(wd), .regwrite(regwrite),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_ready(iss_ready), .pend_cnt(pend_cnt)
    );

    scoreboard_reg_file #(.WIDTH(16), .ADDR_W(2), .BYPASS(0)) dut_nb (
        .clock(clk), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1_nb), .rd2(rd2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .wr(wr), .wd(wd), .regwrite(regwrite),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_ready(iss_ready_nb), .pend_cnt(pend_cnt_nb)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge, checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        regwrite  = 1'b0;
        wr        = 2'd0;
        wd        = 16'h0;
        iss_valid = 1'b0;
        iss_wr    = 2'd0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        idle();
        regwrite = 1'b1;
        wr       = a;
        wd       = d;
        tick();
        idle();
    endtask

    task automatic do_issue(input logic [1:0] a);
        idle();
        iss_valid = 1'b1;
        iss_wr    = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        rr1   = 2'd1;
        rr2   = 2'd2;
        tick();
        tick();
        idle();
        do_write(2'd1, 16'h1234);
        #1;
        total++; if (rd1 !== 16'h1234) $display("FAIL reset_prewrite rd1 got %h exp %h", rd1, 16'h1234); else passed++;
        reset = 1'b1;
        tick();
        idle();
        #1;
        total++; if (rd1 !== 16'h0) $display("FAIL reset_rd1 got %h exp %h", rd1, 16'h0); else passed++;
        total++; if (rd2 !== 16'h0) $display("FAIL reset_rd2 got %h exp %h", rd2, 16'h0); else passed++;
        total++; if (pend_cnt !== 3'd0) $display("FAIL reset_pend_cnt got %0d exp %0d", pend_cnt, 0); else passed++;
        total++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b exp %b", iss_ready, 1'b1); else passed++;
        total++; if ({busy1, busy2} !== 2'b00) $display("FAIL reset_busy got %b exp %b", {busy1, busy2}, 2'b00); else passed++;
    endtask

    task automatic test_basic();
        do_write(2'd2, 16'h0007);
        rr1 = 2'd2;
        rr2 = 2'd0;
        #1;
        total++; if (rd1 !== 16'h0007) $display("FAIL basic_rd1 got %h exp %h", rd1, 16'h0007); else passed++;
        total++; if (rd2 !== 16'h0) $display("FAIL basic_rd2_r0 got %h exp %h", rd2, 16'h0); else passed++;
        total++; if (busy1 !== 1'b0) $display("FAIL basic_busy1 got %b exp %b", busy1, 1'b0); else passed++;
        do_write(2'd0, 16'hFFFF);
        rr1 = 2'd0;
        rr2 = 2'd2;
        #1;
        total++; if (rd1 !== 16'h0) $display("FAIL basic_r0_write_ignored got %h exp %h", rd1, 16'h0); else passed++;
        total++; if (rd2 !== 16'h0007) $display("FAIL basic_r2_kept got %h exp %h", rd2, 16'h0007); else passed++;
    endtask

    task automatic test_scoreboard();
        do_issue(2'd3);
        rr1 = 2'd3;
        rr2 = 2'd3;
        #1;
        total++; if (busy1 !== 1'b1) $display("FAIL sb_busy1 got %b exp %b", busy1, 1'b1); else passed++;
        total++; if (busy2 !== busy1) $display("FAIL sb_same_port_busy got %b exp %b", busy2, 1'b1); else passed++;
        total++; if (pend_cnt !== 3'd1) $display("FAIL sb_pend_cnt got %0d exp %0d", pend_cnt, 1); else passed++;
        iss_valid = 1'b1;
        iss_wr    = 2'd3;
        #1;
        total++; if (iss_ready !== 1'b0) $display("FAIL sb_waw_ready got %b exp %b", iss_ready, 1'b0); else passed++;
        tick();
        idle();
        #1;
        total++; if (pend_cnt !== 3'd1) $display("FAIL sb_waw_pend_cnt got %0d exp %0d", pend_cnt, 1); else passed++;
        do_write(2'd3, 16'h0016);
        #1;
        total++; if (busy1 !== 1'b0) $display("FAIL sb_cleared_busy1 got %b exp %b", busy1, 1'b0); else passed++;
        total++; if (pend_cnt !== 3'd0) $display("FAIL sb_cleared_pend_cnt got %0d exp %0d", pend_cnt, 0); else passed++;
        total++; if (rd1 !== 16'h0016) $display("FAIL sb_written_rd1 got %h exp %h", rd1, 16'h0016); else passed++;
    endtask

    task automatic test_bypass();
        do_write(2'd1, 16'h0005);
        do_issue(2'd1);
        rr1      = 2'd1;
        rr2      = 2'd2;
        regwrite = 1'b1;
        wr       = 2'd1;
        wd       = 16'h000F;
        #1;
        total++; if (rd1 !== 16'h000F) $display("FAIL byp_rd1 got %h exp %h", rd1, 16'h000F); else passed++;
        total++; if (busy1 !== 1'b0) $display("FAIL byp_busy1 got %b exp %b", busy1, 1'b0); else passed++;
        total++; if (rd1_nb !== 16'h0005) $display("FAIL nobyp_rd1 got %h exp %h", rd1_nb, 16'h0005); else passed++;
        total++; if (busy1_nb !== 1'b1) $display("FAIL nobyp_busy1 got %b exp %b", busy1_nb, 1'b1); else passed++;
        total++; if (rd2 !== 16'h0007) $display("FAIL byp_other_port got %h exp %h", rd2, 16'h0007); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy1_nb !== 1'b0) $display("FAIL nobyp_release_busy1 got %b exp %b", busy1_nb, 1'b0); else passed++;
        total++; if (rd1_nb !== 16'h000F) $display("FAIL nobyp_landed_rd1 got %h exp %h", rd1_nb, 16'h000F); else passed++;
    endtask

    task automatic test_back_to_back();
        do_issue(2'd2);
        regwrite  = 1'b1;
        wr        = 2'd2;
        wd        = 16'h0008;
        iss_valid = 1'b1;
        iss_wr    = 2'd2;
        #1;
        total++; if (iss_ready !== 1'b1) $display("FAIL same_cycle_ready got %b exp %b", iss_ready, 1'b1); else passed++;
        total++; if (iss_ready_nb !== 1'b1) $display("FAIL same_cycle_ready_nb got %b exp %b", iss_ready_nb, 1'b1); else passed++;
        tick();
        idle();
        rr1 = 2'd2;
        rr2 = 2'd2;
        #1;
        total++; if (rd1 !== 16'h0008) $display("FAIL same_cycle_data got %h exp %h", rd1, 16'h0008); else passed++;
        total++; if (busy1 !== 1'b1) $display("FAIL same_cycle_busy got %b exp %b", busy1, 1'b1); else passed++;
        total++; if (pend_cnt !== 3'd1) $display("FAIL same_cycle_pend_cnt got %0d exp %0d", pend_cnt, 1); else passed++;
        total++; if (rd2 !== rd1 || busy2 !== busy1) $display("FAIL same_addr_ports got %h/%b exp %h/%b", rd2, busy2, 16'h0008, 1'b1); else passed++;
        do_issue(2'd1);
        do_issue(2'd3);
        iss_valid = 1'b1;
        iss_wr    = 2'd0;
        #1;
        total++; if (pend_cnt !== 3'd3) $display("FAIL b2b_pend_cnt got %0d exp %0d", pend_cnt, 3); else passed++;
        total++; if (iss_ready !== 1'b1) $display("FAIL b2b_r0_ready got %b exp %b", iss_ready, 1'b1); else passed++;
        idle();
    endtask

    task automatic test_reset_midop();
        reset     = 1'b1;
        regwrite  = 1'b1;
        wr        = 2'd1;
        wd        = 16'h00AA;
        iss_valid = 1'b1;
        iss_wr    = 2'd2;
        tick();
        idle();
        rr1 = 2'd1;
        rr2 = 2'd3;
        #1;
        total++; if (pend_cnt !== 3'd0) $display("FAIL midrst_pend_cnt got %0d exp %0d", pend_cnt, 0); else passed++;
        total++; if (rd1 !== 16'h0) $display("FAIL midrst_rd1 got %h exp %h", rd1, 16'h0); else passed++;
        total++; if ({busy1, busy2} !== 2'b00) $display("FAIL midrst_busy got %b exp %b", {busy1, busy2}, 2'b00); else passed++;
        rr2 = 2'd2;
        #1;
        total++; if (rd2 !== 16'h0 || busy2 !== 1'b0) $display("FAIL midrst_r2 got %h/%b exp %h/%b", rd2, busy2, 16'h0, 1'b0); else passed++;
    endtask

    initial begin
        idle();
        rr1 = 2'd0;
        rr2 = 2'd0;
        test_reset();
        test_basic();
        test_scoreboard();
        test_bypass();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
